// File: rtl/bulls_cows_game_fsm.sv
// Two-player Bulls & Cows referee: secret setup, alternating guesses,
// registered scoring and saturating win counters.
module bulls_cows_game_fsm (
  input  logic        clock,
  input  logic        reset,
  input  logic        confirm,
  input  logic [15:0] code_in,
  output logic [7:0]  J1_points,
  output logic [7:0]  J2_points,
  output logic [2:0]  bull_count,
  output logic [2:0]  cow_count,
  output logic [2:0]  game_state,
  output logic        invalid
);

  typedef enum logic [2:0] {
    J1_SETUP = 3'd0,
    J2_SETUP = 3'd1,
    J1_GUESS = 3'd2,
    J2_GUESS = 3'd3,
    J1_WIN   = 3'd4,
    J2_WIN   = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_secret1;
  logic [15:0] r_secret2;
  logic [7:0]  r_j1_pts;
  logic [7:0]  r_j2_pts;
  logic [2:0]  r_bulls;
  logic [2:0]  r_cows;
  logic        r_invalid;

  logic [15:0] w_secret;
  logic [3:0]  w_g [4];
  logic [3:0]  w_s [4];
  logic        w_valid;
  logic        w_hit;
  logic [2:0]  w_bulls;
  logic [2:0]  w_hits;
  logic [2:0]  w_cows;

  // J1 guesses against secret2, J2 against secret1
  assign w_secret = (r_state == J1_GUESS) ? r_secret2 : r_secret1;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_g[i] = code_in[4*i +: 4];
      w_s[i] = w_secret[4*i +: 4];
    end
  end

  always_comb begin
    w_valid = 1'b1;
    w_bulls = '0;
    w_hits  = '0;
    w_hit   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (w_g[i] > 4'd9)
        w_valid = 1'b0;
      for (int j = i + 1; j < 4; j++)
        if (w_g[i] == w_g[j])
          w_valid = 1'b0;
      if (w_g[i] == w_s[i])
        w_bulls = w_bulls + 3'd1;
      w_hit = 1'b0;
      for (int j = 0; j < 4; j++)
        if (w_g[i] == w_s[j])
          w_hit = 1'b1;
      if (w_hit)
        w_hits = w_hits + 3'd1;
    end
    w_cows = w_hits - w_bulls;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= J1_SETUP;
      r_secret1 <= '0;
      r_secret2 <= '0;
      r_j1_pts  <= '0;
      r_j2_pts  <= '0;
      r_bulls   <= '0;
      r_cows    <= '0;
      r_invalid <= 1'b0;
    end else begin
      r_invalid <= 1'b0;
      case (r_state)
        J1_SETUP, J2_SETUP: begin
          if (confirm) begin
            if (!w_valid) begin
              r_invalid <= 1'b1;
            end else if (r_state == J1_SETUP) begin
              r_secret1 <= code_in;
              r_state   <= J2_SETUP;
            end else begin
              r_secret2 <= code_in;
              r_state   <= J1_GUESS;
            end
          end
        end
        J1_GUESS, J2_GUESS: begin
          if (confirm) begin
            if (!w_valid) begin
              r_invalid <= 1'b1;
            end else begin
              r_bulls <= w_bulls;
              r_cows  <= w_cows;
              if (w_bulls == 3'd4) begin
                if (r_state == J1_GUESS) begin
                  if (r_j1_pts != 8'hFF)
                    r_j1_pts <= r_j1_pts + 8'd1;
                  r_state <= J1_WIN;
                end else begin
                  if (r_j2_pts != 8'hFF)
                    r_j2_pts <= r_j2_pts + 8'd1;
                  r_state <= J2_WIN;
                end
              end else begin
                r_state <= (r_state == J1_GUESS) ?
                           J2_GUESS : J1_GUESS;
              end
            end
          end
        end
        J1_WIN, J2_WIN: begin
          if (confirm) begin
            r_secret1 <= '0;
            r_secret2 <= '0;
            r_bulls   <= '0;
            r_cows    <= '0;
            r_state   <= J1_SETUP;
          end
        end
        default: r_state <= J1_SETUP;
      endcase
    end
  end

  assign game_state = r_state;
  assign J1_points  = r_j1_pts;
  assign J2_points  = r_j2_pts;
  assign bull_count = r_bulls;
  assign cow_count  = r_cows;
  assign invalid    = r_invalid;

endmodule

// File: tb/tb_bulls_cows_game_fsm.sv
// Bench for bulls_cows_game_fsm: directed vector table, saturation and
// mid-turn reset sequences, then random play against a reference model.
module tb_bulls_cows_game_fsm;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        confirm = 1'b0;
  logic [15:0] code_in = '0;
  logic [7:0]  J1_points;
  logic [7:0]  J2_points;
  logic [2:0]  bull_count;
  logic [2:0]  cow_count;
  logic [2:0]  game_state;
  logic        invalid;

  int n_tests = 0;
  int n_fail  = 0;

  bulls_cows_game_fsm dut (
    .clock      (clock),
    .reset      (reset),
    .confirm    (confirm),
    .code_in    (code_in),
    .J1_points  (J1_points),
    .J2_points  (J2_points),
    .bull_count (bull_count),
    .cow_count  (cow_count),
    .game_state (game_state),
    .invalid    (invalid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        c;
    logic [15:0] code;
    int          st;
    int          b;
    int          cw;
    int          inv;
    int          j1;
    int          j2;
    string       nm;
  } vec_t;

  vec_t vt[16];

  // reference model state (game phase uses the output encoding)
  int          m_phase;
  logic [15:0] m_s1, m_s2;
  int          m_j1, m_j2, m_b, m_c, m_inv;

  task automatic cmp(input string nm, input int est, input int eb,
                     input int ec, input int ei, input int ej1,
                     input int ej2);
    n_tests++;
    if (int'(game_state) != est || int'(bull_count) != eb ||
        int'(cow_count) != ec || int'(invalid) != ei ||
        int'(J1_points) != ej1 || int'(J2_points) != ej2) begin
      n_fail++;
      $display("FAIL %s: got st=%0d b=%0d c=%0d inv=%0d j1=%0d j2=%0d; exp st=%0d b=%0d c=%0d inv=%0d j1=%0d j2=%0d",
               nm, game_state, bull_count, cow_count, invalid,
               J1_points, J2_points, est, eb, ec, ei, ej1, ej2);
    end
  endtask

  function automatic int digit(input logic [15:0] v, input int i);
    return int'(v[4*i +: 4]);
  endfunction

  function automatic bit code_ok(input logic [15:0] v);
    logic [15:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      if (digit(v, i) > 9) return 1'b0;
      mask[digit(v, i)] = 1'b1;
    end
    return $countones(mask) == 4;
  endfunction

  function automatic void score(input logic [15:0] g, input logic [15:0] s,
                                output int b, output int c);
    logic [15:0] smask;
    int hits;
    smask = '0;
    b = 0;
    hits = 0;
    for (int i = 0; i < 4; i++) smask[digit(s, i)] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (digit(g, i) == digit(s, i)) b++;
      if (smask[digit(g, i)]) hits++;
    end
    c = hits - b;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_s1 = '0; m_s2 = '0;
    m_j1 = 0; m_j2 = 0; m_b = 0; m_c = 0; m_inv = 0;
  endfunction

  function automatic void model_step(input logic c, input logic [15:0] v);
    int b, cw;
    m_inv = 0;
    if (!c) return;
    if (m_phase == 0 || m_phase == 1) begin
      if (!code_ok(v)) m_inv = 1;
      else begin
        if (m_phase == 0) m_s1 = v; else m_s2 = v;
        m_phase++;
      end
    end else if (m_phase == 2 || m_phase == 3) begin
      if (!code_ok(v)) m_inv = 1;
      else begin
        score(v, (m_phase == 2) ? m_s2 : m_s1, b, cw);
        m_b = b;
        m_c = cw;
        if (b == 4) begin
          if (m_phase == 2) m_j1 = (m_j1 < 255) ? m_j1 + 1 : 255;
          else              m_j2 = (m_j2 < 255) ? m_j2 + 1 : 255;
          m_phase = m_phase + 2;
        end else begin
          m_phase = 5 - m_phase;
        end
      end
    end else begin
      m_s1 = '0; m_s2 = '0; m_b = 0; m_c = 0;
      m_phase = 0;
    end
  endfunction

  task automatic drive(input logic c, input logic [15:0] v);
    @(negedge clock);
    confirm = c;
    code_in = v;
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic c, input logic [15:0] v);
    drive(c, v);
    model_step(c, v);
    cmp("model", m_phase, m_b, m_c, m_inv, m_j1, m_j2);
  endtask

  task automatic do_reset();
    @(negedge clock);
    confirm = 1'b0;
    reset = 1'b1;
    #1;
    cmp("reset", 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic play_win(input int player);
    step(1'b1, 16'h1234);
    step(1'b1, 16'h5678);
    if (player == 1) begin
      step(1'b1, 16'h5678);
    end else begin
      step(1'b1, 16'h1234);
      step(1'b1, 16'h1234);
    end
    step(1'b1, 16'h0000);
  endtask

  function automatic logic [15:0] rand_valid();
    int d[10];
    int t, k;
    logic [15:0] v;
    for (int i = 0; i < 10; i++) d[i] = i;
    for (int i = 0; i < 4; i++) begin
      k = $urandom_range(9, i);
      t = d[i]; d[i] = d[k]; d[k] = t;
    end
    v = '0;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'(d[i]);
    return v;
  endfunction

  initial begin
    vt[0]  = '{1'b1, 16'h1234, 1, 0, 0, 0, 0, 0, "setup1"};
    vt[1]  = '{1'b1, 16'h5678, 2, 0, 0, 0, 0, 0, "setup2"};
    vt[2]  = '{1'b1, 16'h8765, 3, 0, 4, 0, 0, 0, "j1_cows4"};
    vt[3]  = '{1'b1, 16'h1234, 5, 4, 0, 0, 0, 1, "j2_win"};
    vt[4]  = '{1'b1, 16'h9999, 0, 0, 0, 0, 0, 1, "win_exit"};
    vt[5]  = '{1'b1, 16'h1123, 0, 0, 0, 1, 0, 1, "inv_dup"};
    vt[6]  = '{1'b0, 16'h0000, 0, 0, 0, 0, 0, 1, "inv_low1"};
    vt[7]  = '{1'b1, 16'h12A4, 0, 0, 0, 1, 0, 1, "inv_bcd"};
    vt[8]  = '{1'b0, 16'h12A4, 0, 0, 0, 0, 0, 1, "inv_low2"};
    vt[9]  = '{1'b1, 16'h0123, 1, 0, 0, 0, 0, 1, "setup1b"};
    vt[10] = '{1'b1, 16'h4567, 2, 0, 0, 0, 0, 1, "setup2b"};
    vt[11] = '{1'b1, 16'h4576, 3, 2, 2, 0, 0, 1, "j1_b2c2"};
    vt[12] = '{1'b1, 16'h1223, 3, 2, 2, 1, 0, 1, "j2_inv"};
    vt[13] = '{1'b1, 16'h3210, 2, 0, 4, 0, 0, 1, "j2_c4"};
    vt[14] = '{1'b1, 16'h4567, 4, 4, 0, 0, 1, 1, "j1_win"};
    vt[15] = '{1'b0, 16'h4567, 4, 4, 0, 0, 1, 1, "idle"};

    #2;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].c, vt[i].code);
      cmp(vt[i].nm, vt[i].st, vt[i].b, vt[i].cw, vt[i].inv,
          vt[i].j1, vt[i].j2);
    end

    // saturation: 255 J1 wins, then one more
    do_reset();
    for (int i = 0; i < 255; i++) play_win(1);
    step(1'b1, 16'h1234);
    step(1'b1, 16'h5678);
    step(1'b1, 16'h5678);
    cmp("sat", 4, 4, 0, 0, 255, 0);

    // mid-turn asynchronous reset with points 3/2 in J2_GUESS
    do_reset();
    for (int i = 0; i < 3; i++) play_win(1);
    for (int i = 0; i < 2; i++) play_win(2);
    step(1'b1, 16'h1234);
    step(1'b1, 16'h5678);
    step(1'b1, 16'h1234);
    cmp("pre_rst", 3, 0, 0, 0, 3, 2);
    @(negedge clock);
    confirm = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    cmp("async_rst", 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(1'b1, 16'h9876);
    model_step(1'b1, 16'h9876);
    cmp("post_rst", 1, 0, 0, 0, 0, 0);

    // random play
    for (int n = 0; n < 3000; n++) begin
      logic c;
      logic [15:0] v;
      int r;
      if ($urandom_range(299, 0) == 0) do_reset();
      c = ($urandom_range(3, 0) != 0);
      r = $urandom_range(7, 0);
      if (r == 0)
        v = 16'($urandom);
      else if (r <= 2)
        v = (m_phase == 2) ? m_s2 : m_s1;
      else
        v = rand_valid();
      step(c, v);
    end

    @(negedge clock);
    confirm = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
